xor_stream_cipher_ctrl: RTL and testbench



---
 rtl/xor_cipher_pkg.sv | 32 +++
 rtl/bitwise_xor.sv | 13 +
 rtl/xor_stream_cipher_ctrl.sv | 140 ++++++++++++++
 tb/tb_xor_stream_cipher_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// rtl/xor_cipher_pkg.sv - shared types, constants and keystream helpers for the XOR stream cipher controller
// Contents: state_e FSM encoding, LFSR_TAPS, ZERO_KEY_SEED, ks_seed() and ks_next().
// Optional feature macro: XOR_KEY_ROTATE_EN (rotating LFSR keystream instead of a fixed key byte).
package xor_cipher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] ZERO_KEY_SEED = 8'h01;

    // Initial keystream byte for a message. With rotation enabled a zero key
    // would lock the LFSR at zero, so it is replaced by a non-zero seed.
    function automatic logic [7:0] ks_seed(input logic [7:0] key);
`ifdef XOR_KEY_ROTATE_EN
        return (key == 8'h00) ? ZERO_KEY_SEED : key;
`else
        return key;
`endif
    endfunction

`ifdef XOR_KEY_ROTATE_EN
    // One step of the right-shifting Galois LFSR.
    function automatic logic [7:0] ks_next(input logic [7:0] ks);
        return {1'b0, ks[7:1]} ^ (ks[0] ? LFSR_TAPS : 8'h00);
    endfunction
`endif

endpackage

// File: rtl/bitwise_xor.sv
// rtl/bitwise_xor.sv - W-bit combinational XOR datapath
// Ports: a, b - operands; y - a ^ b.
module bitwise_xor #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_stream_cipher_ctrl.sv
// rtl/xor_stream_cipher_ctrl.sv - sequences bitwise_xor over a byte stream of programmed length
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   key_load, key_in          - key register write (IDLE only, wins over start)
//   start, len                - begin a message of len bytes (IDLE only, len != 0)
//   busy, done                - busy in RUN/FLUSH; done pulses once the last byte is consumed
//   in_valid, in_data, in_ready     - input byte stream handshake
//   out_valid, out_data, out_ready  - output byte stream handshake
// Optional feature macro: XOR_KEY_ROTATE_EN (keystream advances by LFSR per accepted byte).
module xor_stream_cipher_ctrl
    import xor_cipher_pkg::*;
#(
    parameter int         LEN_W   = 8,
    parameter logic [7:0] RST_KEY = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [7:0]       key_in,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready
);

    localparam logic [LEN_W-1:0] CNT_ZERO = '0;
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e           state_q,     state_d;
    logic [7:0]       key_q,       key_d;
    logic [7:0]       ks_q,        ks_d;
    logic [LEN_W-1:0] count_q,     count_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q,  out_data_d;
    logic             done_q,      done_d;

    logic [7:0]       xor_y;
    logic             accept;

    bitwise_xor #(.W(8)) u_xor (
        .a (in_data),
        .b (ks_q),
        .y (xor_y)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            key_q       <= RST_KEY;
            ks_q        <= 8'h00;
            count_q     <= CNT_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            ks_q        <= ks_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        ks_d        = ks_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // key_load has priority so a message never starts with a
                // key that is changing in the same cycle.
                if (key_load) begin
                    key_d = key_in;
                end else if (start && (len != CNT_ZERO)) begin
                    count_d = len;
                    ks_d    = ks_seed(key_q);
                    state_d = RUN;
                end
            end

            RUN: begin
                // Drain first; a same-cycle accept overrides and keeps out_valid high.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    out_data_d  = xor_y;
                    out_valid_d = 1'b1;
`ifdef XOR_KEY_ROTATE_EN
                    ks_d        = ks_next(ks_q);
`endif
                    // The last byte parks the counter at 1 rather than 0.
                    if (count_q == CNT_ONE) begin
                        state_d = FLUSH;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end

            FLUSH: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q != IDLE);
        in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
        accept    = in_valid && in_ready;
        done      = done_q;
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

endmodule

// File: tb/tb_xor_stream_cipher_ctrl.sv
// tb/tb_xor_stream_cipher_ctrl.sv - scoreboard bench for xor_stream_cipher_ctrl (either XOR_KEY_ROTATE_EN setting)
module tb_xor_stream_cipher_ctrl;

    localparam int         LEN_W      = 8;
    localparam logic [7:0] TB_RST_KEY = 8'h5A;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_load = 1'b0;
    logic [7:0]       key_in = 8'h00;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             out_ready = 1'b0;
    logic             busy, done, in_ready, out_valid;
    logic [7:0]       out_data;

    always #5 clk = ~clk;

    xor_stream_cipher_ctrl #(.LEN_W(LEN_W), .RST_KEY(TB_RST_KEY)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int n_out   = 0;
    int n_done  = 0;
    int cyc_no  = 0;

    logic [7:0] sb[$];
    logic [7:0] out_log[$];
    int         out_cyc[$];
    logic [7:0] m_key = TB_RST_KEY;
    logic [7:0] m_ks  = 8'h00;

    function automatic logic [7:0] m_seed(input logic [7:0] k);
`ifdef XOR_KEY_ROTATE_EN
        return (k == 8'h00) ? 8'h01 : k;
`else
        return k;
`endif
    endfunction

    function automatic logic [7:0] m_adv(input logic [7:0] ks);
`ifdef XOR_KEY_ROTATE_EN
        return (ks >> 1) ^ (ks[0] ? 8'hB8 : 8'h00);
`else
        return ks;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: observe handshakes with inputs settled, then advance.
    task automatic tick();
        #1;
        if (out_valid === 1'b1 && out_ready) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("out_data", 32'(out_data), 32'(sb.pop_front()));
            out_log.push_back(out_data);
            out_cyc.push_back(cyc_no);
            n_out++;
        end
        if (in_valid && in_ready === 1'b1) begin
            sb.push_back(in_data ^ m_ks);
            m_ks = m_adv(m_ks);
            n_acc++;
        end
        if (done === 1'b1) begin
            n_done++;
            chk("busy_low_at_done", 32'(busy), 0);
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic load_key(input logic [7:0] k);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load = 1'b0;
        m_key    = k;
    endtask

    task automatic begin_msg(input logic [LEN_W-1:0] n);
        start = 1'b1;
        len   = n;
        m_ks  = m_seed(m_key);
        tick();
        start = 1'b0;
    endtask

    // Leaves in_valid high so back-to-back calls stream on consecutive cycles.
    task automatic put(input logic [7:0] b);
        int a0;
        a0       = n_acc;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && n_acc == a0; i++) tick();
        chk("accept_in_time", 32'(n_acc - a0), 1);
    endtask

    task automatic wait_done();
        int d0;
        d0       = n_done;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && n_done == d0; i++) tick();
        chk("done_seen", 32'(n_done - d0), 1);
        for (int i = 0; i < 3; i++) tick();
        chk("done_once", 32'(n_done - d0), 1);
        chk("sb_drained", 32'(sb.size()), 0);
    endtask

    initial begin
        logic [7:0] orig[4];
        logic [7:0] ciph[4];
        logic [7:0] held;
        int         base, d0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();

        // Basic message, streamed back to back
        load_key(8'h3C);
        begin_msg(3);
        chk("busy_in_run", 32'(busy), 1);
        base = out_log.size();
        put(8'h55);
        put(8'h00);
        put(8'hFF);
        wait_done();
        chk("basic_count", 32'(out_log.size() - base), 3);
        chk("basic_consecutive", 32'(out_cyc[base+2] - out_cyc[base]), 2);
`ifndef XOR_KEY_ROTATE_EN
        chk("basic_b0", 32'(out_log[base]),   32'h69);
        chk("basic_b1", 32'(out_log[base+1]), 32'h3C);
        chk("basic_b2", 32'(out_log[base+2]), 32'hC3);
`else
        // Zero key: seed substitution and LFSR sequence
        load_key(8'h00);
        begin_msg(3);
        base = out_log.size();
        put(8'h00);
        put(8'h00);
        put(8'h00);
        wait_done();
        chk("lfsr_b0", 32'(out_log[base]),   32'h01);
        chk("lfsr_b1", 32'(out_log[base+1]), 32'hB8);
        chk("lfsr_b2", 32'(out_log[base+2]), 32'h5C);
`endif

        // Backpressure: stall 3 cycles after first byte
        load_key(8'h96);
        begin_msg(4);
        base = out_log.size();
        put(8'h11);
        in_data   = 8'h22;
        out_ready = 1'b0;
        #1;
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_out_data", 32'(out_data), 32'(held));
            tick();
        end
        out_ready = 1'b1;
        put(8'h22);
        put(8'h33);
        put(8'h44);
        wait_done();
        chk("bp_count", 32'(out_log.size() - base), 4);

        // Round trip encrypt/decrypt
        orig[0] = 8'hDE; orig[1] = 8'hAD; orig[2] = 8'hBE; orig[3] = 8'hEF;
        load_key(8'hA7);
        begin_msg(4);
        base = out_log.size();
        for (int i = 0; i < 4; i++) put(orig[i]);
        wait_done();
        for (int i = 0; i < 4; i++) ciph[i] = out_log[base+i];
        begin_msg(4);
        base = out_log.size();
        for (int i = 0; i < 4; i++) put(ciph[i]);
        wait_done();
        for (int i = 0; i < 4; i++) chk("roundtrip", 32'(out_log[base+i]), 32'(orig[i]));

        // Controls ignored in RUN
        load_key(8'h3C);
        begin_msg(4);
        put(8'h01);
        key_load = 1'b1;
        key_in   = 8'hFF;
        start    = 1'b1;
        len      = 1;
        put(8'h02);
        key_load = 1'b0;
        start    = 1'b0;
        put(8'h03);
        put(8'h04);
        wait_done();
        begin_msg(1);
        put(8'h80);
        wait_done();

        // start with len == 0 is ignored
        d0    = n_done;
        start = 1'b1;
        len   = 0;
        tick();
        start = 1'b0;
        chk("len0_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) tick();
        chk("len0_no_done", 32'(n_done - d0), 0);

        // Reset mid-message
        load_key(8'h77);
        begin_msg(5);
        put(8'h01);
        put(8'h02);
        in_valid = 1'b0;
        d0  = n_done;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        sb.delete();
        m_key = TB_RST_KEY;
        for (int i = 0; i < 3; i++) tick();
        chk("midrst_no_done", 32'(n_done - d0), 0);
        begin_msg(2);
        base = out_log.size();
        put(8'hAA);
        put(8'h55);
        wait_done();
        chk("post_rst_count", 32'(out_log.size() - base), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
